axi_mailbox_slave: RTL and testbench

//  AXI4 (32-bit) slave hung on the Rocket harness wrapperio_m_axi port, beside the BRAM controller; a consumer of core MMIO.

---
 rtl/axi_mailbox_pkg.sv | 38 +++
 rtl/axi_mailbox_if.sv | 59 +++++
 rtl/mailbox_fifo.sv | 53 +++++
 rtl/axi_mailbox_slave.sv | 220 ++++++++++++++++++++++
 tb/tb_axi_mailbox_slave.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_mailbox_pkg.sv
// axi_mailbox_pkg: register offsets, STATUS bit positions, AXI encodings and FSM states.
// Rev 1.0
`default_nettype none

package axi_mailbox_pkg;
    localparam logic [7:0] OFF_TX_DATA    = 8'h00;
    localparam logic [7:0] OFF_RX_DATA    = 8'h04;
    localparam logic [7:0] OFF_STATUS     = 8'h08;
    localparam logic [7:0] OFF_IRQ_EN     = 8'h0C;
    localparam logic [7:0] OFF_IRQ_STATUS = 8'h10;

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;
endpackage

`default_nettype wire

// File: rtl/axi_mailbox_if.sv
// axi_mailbox_if: 32-bit AXI4 bus bundle seen by the mailbox slave.
// Rev 1.0
`default_nettype none

interface axi_mailbox_if;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

`default_nettype wire

// File: rtl/mailbox_fifo.sv
// mailbox_fifo: synchronous word FIFO with occupancy count; push refused when full, pop when empty.
// Rev 1.0
`default_nettype none

module mailbox_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    input  wire logic                  push_i,
    input  wire logic [WIDTH-1:0]      data_i,
    input  wire logic                  pop_i,
    output logic      [WIDTH-1:0]      data_o,
    output logic      [DEPTH_LOG2:0]   count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push;
    logic                  do_pop;

    // Full/empty come from the registered count, so a pop never frees a slot for a same-cycle push.
    assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

`default_nettype wire

// File: rtl/axi_mailbox_slave.sv
// axi_mailbox_slave: AXI4 slave exposing a TX and an RX word FIFO to the core, with a level interrupt.
// Rev 1.0
`default_nettype none

module axi_mailbox_slave
    import axi_mailbox_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_BITS  = 5
) (
    input  wire logic        clock,
    input  wire logic        reset,
    axi_mailbox_if.slave     s_axi,
    output logic [31:0]      tx_data,
    output logic             tx_valid,
    input  wire logic        tx_ready,
    input  wire logic [31:0] rx_data,
    input  wire logic        rx_valid,
    output logic             rx_ready,
    output logic             irq
);
    wr_state_e              wstate_q, wstate_d;
    logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
    logic [1:0]             wburst_q, wburst_d;
    logic                   werr_q, werr_d;
    rd_state_e              rstate_q, rstate_d;
    logic [ADDR_BITS-1:0]   raddr_q;
    logic [1:0]             rburst_q;
    logic [7:0]             rlen_q, rbeat_q;
    logic                   rvalid_q, rlast_q, rpop_q;
    logic [31:0]            rdata_q;
    logic [1:0]             rresp_q;
    logic [1:0]             irq_en_q, irq_en_d;
    logic [1:0]             irq_status_q, irq_status_d;
    logic                   irq_q;

    logic                   tx_push, tx_pop, tx_full, tx_empty;
    logic                   rx_push, rx_pop, rx_full, rx_empty;
    logic [DEPTH_LOG2:0]    tx_count, rx_count;
    logic [31:0]            rx_head;
    logic                   irq_en_we;
    logic [1:0]             irq_clr, irq_evt;
    logic                   r_accept, r_load, r_hs, rd_err, rd_pop;
    logic [31:0]            rd_word;
    logic                   unused_bits;

    assign unused_bits = ^{s_axi.awaddr[31:ADDR_BITS], s_axi.araddr[31:ADDR_BITS],
                           s_axi.awsize, s_axi.arsize, s_axi.awlen};

    mailbox_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clock(clock), .reset(reset), .push_i(tx_push), .data_i(s_axi.wdata), .pop_i(tx_pop),
        .data_o(tx_data), .count_o(tx_count), .full_o(tx_full), .empty_o(tx_empty)
    );

    mailbox_fifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clock(clock), .reset(reset), .push_i(rx_push), .data_i(rx_data), .pop_i(rx_pop),
        .data_o(rx_head), .count_o(rx_count), .full_o(rx_full), .empty_o(rx_empty)
    );

    assign tx_valid = ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign rx_ready = ~rx_full & ~reset;
    assign rx_push  = rx_valid & ~rx_full;

    // Write channel
    always_comb begin
        wstate_d  = wstate_q;
        waddr_d   = waddr_q;
        wburst_d  = wburst_q;
        werr_d    = werr_q;
        tx_push   = 1'b0;
        irq_en_we = 1'b0;
        irq_clr   = 2'b00;
        case (wstate_q)
            W_IDLE: if (s_axi.awvalid) begin
                waddr_d  = s_axi.awaddr[ADDR_BITS-1:0];
                wburst_d = s_axi.awburst;
                werr_d   = (s_axi.awburst == BURST_WRAP);
                wstate_d = W_DATA;
            end
            W_DATA: if (s_axi.wvalid) begin
                if (wburst_q != BURST_WRAP) begin
                    if (waddr_q == ADDR_BITS'(OFF_TX_DATA)) begin
                        if (s_axi.wstrb == 4'hF && !tx_full) tx_push = 1'b1;
                        else                                 werr_d  = 1'b1;
                    end else if (waddr_q == ADDR_BITS'(OFF_IRQ_EN)) begin
                        irq_en_we = s_axi.wstrb[0];
                    end else if (waddr_q == ADDR_BITS'(OFF_IRQ_STATUS)) begin
                        irq_clr = s_axi.wstrb[0] ? s_axi.wdata[1:0] : 2'b00;
                    end
                    if (wburst_q == BURST_INCR) waddr_d = waddr_q + ADDR_BITS'(4);
                end
                if (s_axi.wlast) wstate_d = W_RESP;
            end
            W_RESP: if (s_axi.bready) wstate_d = W_IDLE;
            default: wstate_d = W_IDLE;
        endcase
    end

    assign s_axi.awready = (wstate_q == W_IDLE) & ~reset;
    assign s_axi.wready  = (wstate_q == W_DATA);
    assign s_axi.bvalid  = (wstate_q == W_RESP);
    assign s_axi.bresp   = (s_axi.bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    // Read channel: each beat is loaded one cycle, presented, then popped on its handshake.
    always_comb begin
        rstate_d = rstate_q;
        r_accept = 1'b0;
        r_load   = 1'b0;
        r_hs     = 1'b0;
        case (rstate_q)
            R_IDLE: if (s_axi.arvalid) begin
                r_accept = 1'b1;
                rstate_d = R_DATA;
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    r_load = 1'b1;
                end else if (s_axi.rready) begin
                    r_hs = 1'b1;
                    if (rlast_q) rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        rd_word = '0;
        rd_err  = 1'b0;
        rd_pop  = 1'b0;
        case (raddr_q)
            ADDR_BITS'(OFF_RX_DATA): begin
                if (rx_empty) begin
                    rd_err = 1'b1;
                end else begin
                    rd_word = rx_head;
                    rd_pop  = 1'b1;
                end
            end
            ADDR_BITS'(OFF_STATUS): begin
                rd_word[ST_TX_EMPTY]           = tx_empty;
                rd_word[ST_TX_FULL]            = tx_full;
                rd_word[ST_RX_EMPTY]           = rx_empty;
                rd_word[ST_RX_FULL]            = rx_full;
                rd_word[ST_TX_CNT_LSB +: 8]    = 8'(tx_count);
                rd_word[ST_RX_CNT_LSB +: 8]    = 8'(rx_count);
            end
            ADDR_BITS'(OFF_IRQ_EN):     rd_word[1:0] = irq_en_q;
            ADDR_BITS'(OFF_IRQ_STATUS): rd_word[1:0] = irq_status_q;
            default: rd_word = '0;
        endcase
    end

    assign rx_pop        = r_hs & rpop_q;
    assign s_axi.arready = (rstate_q == R_IDLE) & ~reset;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;

    // Interrupt events are taken from the FIFO updates landing on this same edge.
    assign irq_evt[0]   = rx_push & rx_empty;
    assign irq_evt[1]   = tx_pop & (tx_count == (DEPTH_LOG2+1)'(1)) & ~tx_push;
    assign irq_status_d = (irq_status_q & ~irq_clr) | irq_evt;
    assign irq_en_d     = irq_en_we ? s_axi.wdata[1:0] : irq_en_q;
    assign irq          = irq_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wstate_q     <= W_IDLE;
            waddr_q      <= '0;
            wburst_q     <= BURST_FIXED;
            werr_q       <= 1'b0;
            rstate_q     <= R_IDLE;
            raddr_q      <= '0;
            rburst_q     <= BURST_FIXED;
            rlen_q       <= '0;
            rbeat_q      <= '0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            rpop_q       <= 1'b0;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            irq_en_q     <= 2'b00;
            irq_status_q <= 2'b00;
            irq_q        <= 1'b0;
        end else begin
            wstate_q     <= wstate_d;
            waddr_q      <= waddr_d;
            wburst_q     <= wburst_d;
            werr_q       <= werr_d;
            rstate_q     <= rstate_d;
            irq_en_q     <= irq_en_d;
            irq_status_q <= irq_status_d;
            irq_q        <= |(irq_status_q & irq_en_q);
            if (r_accept) begin
                raddr_q  <= s_axi.araddr[ADDR_BITS-1:0];
                rburst_q <= s_axi.arburst;
                rlen_q   <= s_axi.arlen;
                rbeat_q  <= '0;
            end
            if (r_load) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rlast_q  <= (rbeat_q == rlen_q);
                rpop_q   <= rd_pop;
            end
            if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
                rbeat_q  <= rbeat_q + 8'd1;
                if (rburst_q == BURST_INCR) raddr_q <= raddr_q + ADDR_BITS'(4);
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_axi_mailbox_slave.sv
// tb_axi_mailbox_slave: directed checks of the mailbox register map, FIFOs, IRQ and reset.
// Rev 1.0
`default_nettype none

module tb_axi_mailbox_slave;
    import axi_mailbox_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        irq;

    int n_tests;
    int n_fail;
    int txv_cycles;
    logic [31:0] popq[$];

    axi_mailbox_if s_axi ();

    axi_mailbox_slave #(.DEPTH_LOG2(4), .ADDR_BITS(5)) dut (
        .clock(clock), .reset(reset), .s_axi(s_axi),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Record every TX pop; tx_ready only changes just after a rising edge.
    always @(negedge clock) begin
        if (tx_valid) txv_cycles++;
        if (tx_valid && tx_ready) popq.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input int sel, input string tag);
        int   t;
        logic s;
        t = 0;
        do begin
            @(negedge clock);
            t++;
            case (sel)
                0: s = s_axi.awready;
                1: s = s_axi.wready;
                2: s = s_axi.bvalid;
                3: s = s_axi.arready;
                default: s = s_axi.rvalid;
            endcase
        end while (s !== 1'b1 && t < 50);
        n_tests++;
        assert (s === 1'b1) else begin
            n_fail++;
            $error("FAIL %s handshake timeout: observed %b expected 1", tag, s);
        end
    endtask

    // Called just after a rising edge; beat i carries base+i. Optionally pushes RX on the last beat.
    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [31:0] base, input logic [3:0] strb, input bit push_rx,
                             output logic [1:0] resp);
        s_axi.awaddr = addr; s_axi.awlen = len; s_axi.awburst = burst; s_axi.awsize = 3'd2;
        s_axi.awvalid = 1'b1;
        wait_ready(0, "aw");
        @(posedge clock); #1;
        s_axi.awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            s_axi.wdata = base + 32'(i); s_axi.wstrb = strb;
            s_axi.wlast = (i == int'(len)); s_axi.wvalid = 1'b1;
            wait_ready(1, "w");
            if (push_rx && i == int'(len)) rx_valid = 1'b1;
            @(posedge clock); #1;
            rx_valid = 1'b0;
        end
        s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.bready = 1'b1;
        wait_ready(2, "b");
        resp = s_axi.bresp;
        @(posedge clock); #1;
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output logic last);
        s_axi.araddr = addr; s_axi.arlen = 8'd0; s_axi.arburst = BURST_INCR; s_axi.arsize = 3'd2;
        s_axi.arvalid = 1'b1;
        wait_ready(3, "ar");
        @(posedge clock); #1;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        wait_ready(4, "r");
        data = s_axi.rdata; resp = s_axi.rresp; last = s_axi.rlast;
        @(posedge clock); #1;
        s_axi.rready = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] d);
        rx_data = d; rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    logic [1:0]  resp;
    logic [31:0] rd;
    logic        last;
    int          q0;
    int          v0;

    initial begin
        n_tests = 0; n_fail = 0;
        reset = 1'b1; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0; s_axi.awburst = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0; s_axi.arburst = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_handshakes", {s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready,
                                 s_axi.rvalid, tx_valid, rx_ready, irq}, 32'h0);
        check("rst_rdata", s_axi.rdata, 32'h0);
        check("rst_resps", {s_axi.bresp, s_axi.rresp}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_readys", {s_axi.awready, s_axi.arready, rx_ready, tx_valid}, 32'hE);
        @(posedge clock); #1;

        // Single TX write drained immediately
        tx_ready = 1'b1; q0 = popq.size(); v0 = txv_cycles;
        axi_write(32'h0, 8'd0, BURST_INCR, 32'hDEADBEEF, 4'hF, 1'b0, resp);
        check("single_bresp", resp, RESP_OKAY);
        repeat (3) @(posedge clock); #1;
        check("single_pops", popq.size() - q0, 32'd1);
        check("single_data", popq[q0], 32'hDEADBEEF);
        check("single_valid_cycles", txv_cycles - v0, 32'd1);
        axi_read(32'h10, rd, resp, last);
        check("irqst_tx_empty_evt", rd, 32'h2);
        check("single_rlast", last, 32'h1);
        check("irq_masked", irq, 32'h0);

        // FIXED burst of 4 words while draining
        q0 = popq.size();
        axi_write(32'h0, 8'd3, BURST_FIXED, 32'hA0000000, 4'hF, 1'b0, resp);
        check("fixed4_bresp", resp, RESP_OKAY);
        repeat (4) @(posedge clock); #1;
        check("fixed4_pops", popq.size() - q0, 32'd4);
        check("fixed4_first", popq[q0], 32'hA0000000);
        check("fixed4_last", popq[q0+3], 32'hA0000003);

        // 17 words into a 16-deep FIFO with the consumer stalled
        tx_ready = 1'b0;
        axi_write(32'h0, 8'd16, BURST_FIXED, 32'hB0000000, 4'hF, 1'b0, resp);
        check("overflow_bresp", resp, RESP_SLVERR);
        axi_read(32'h8, rd, resp, last);
        check("status_full", rd, 32'h00001006);
        q0 = popq.size();
        tx_ready = 1'b1;
        repeat (20) @(posedge clock); #1;
        check("overflow_pops", popq.size() - q0, 32'd16);
        check("overflow_first", popq[q0], 32'hB0000000);
        check("overflow_16th", popq[q0+15], 32'hB000000F);

        // Five single writes, then a WRAP burst that must be discarded
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) axi_write(32'h0, 8'd0, BURST_INCR, 32'hC0 + 32'(i), 4'hF, 1'b0, resp);
        axi_read(32'h8, rd, resp, last);
        check("status_5tx", rd, 32'h00000504);
        axi_write(32'h0, 8'd1, BURST_WRAP, 32'hEE000000, 4'hF, 1'b0, resp);
        check("wrap_bresp", resp, RESP_SLVERR);
        axi_read(32'h8, rd, resp, last);
        check("status_after_wrap", rd, 32'h00000504);
        tx_ready = 1'b1;
        repeat (8) @(posedge clock); #1;
        axi_write(32'h0, 8'd0, BURST_INCR, 32'h11111111, 4'h3, 1'b0, resp);
        check("partial_strb_bresp", resp, RESP_SLVERR);
        repeat (2) @(posedge clock); #1;
        axi_read(32'h8, rd, resp, last);
        check("status_empty", rd, 32'h00000005);
        axi_write(32'h14, 8'd0, BURST_INCR, 32'hFFFFFFFF, 4'hF, 1'b0, resp);
        check("unmapped_bresp", resp, RESP_OKAY);
        axi_write(32'h10, 8'd0, BURST_INCR, 32'h3, 4'hF, 1'b0, resp);
        axi_read(32'h10, rd, resp, last);
        check("irqst_cleared", rd, 32'h0);

        // RX path and interrupt
        axi_write(32'hC, 8'd0, BURST_INCR, 32'h1, 4'hF, 1'b0, resp);
        axi_read(32'hC, rd, resp, last);
        check("irq_en_rb", rd, 32'h1);
        rx_push(32'h12345678);
        repeat (2) @(posedge clock); #1;
        check("irq_rise", irq, 32'h1);
        axi_read(32'h4, rd, resp, last);
        check("rx_pop_data", rd, 32'h12345678);
        check("rx_pop_resp", resp, RESP_OKAY);
        axi_read(32'h4, rd, resp, last);
        check("rx_empty_data", rd, 32'h0);
        check("rx_empty_resp", resp, RESP_SLVERR);
        check("irq_held", irq, 32'h1);

        // W1C collides with a push into the empty RX FIFO: set wins
        rx_data = 32'hCAFEF00D;
        axi_write(32'h10, 8'd0, BURST_INCR, 32'h3, 4'hF, 1'b1, resp);
        check("w1c_bresp", resp, RESP_OKAY);
        axi_read(32'h10, rd, resp, last);
        check("irqst_set_wins", rd, 32'h1);
        check("irq_still_high", irq, 32'h1);
        axi_read(32'h4, rd, resp, last);
        check("collide_rx_data", rd, 32'hCAFEF00D);

        // Reset in the middle of an 8-beat read burst
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) axi_write(32'h0, 8'd0, BURST_INCR, 32'h50 + 32'(i), 4'hF, 1'b0, resp);
        rx_push(32'h1); rx_push(32'h2);
        s_axi.araddr = 32'h8; s_axi.arlen = 8'd7; s_axi.arburst = BURST_FIXED; s_axi.arsize = 3'd2;
        s_axi.arvalid = 1'b1;
        wait_ready(3, "ar8");
        @(posedge clock); #1;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        wait_ready(4, "r8_b0");
        check("burst_beat0", s_axi.rdata, 32'h00020300);
        check("burst_beat0_rlast", s_axi.rlast, 32'h0);
        @(posedge clock); #1;
        wait_ready(4, "r8_b1");
        reset = 1'b1;
        #1;
        check("rst_mid_rvalid", s_axi.rvalid, 32'h0);
        check("rst_mid_fifos", {tx_valid, rx_ready, s_axi.arready, irq}, 32'h0);
        s_axi.rready = 1'b0;
        repeat (2) @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("rst_release", {s_axi.arready, s_axi.awready, rx_ready, tx_valid}, 32'hE);
        @(posedge clock); #1;
        axi_read(32'h8, rd, resp, last);
        check("rst_status", rd, 32'h00000005);
        axi_read(32'hC, rd, resp, last);
        check("rst_irq_en", rd, 32'h0);
        check("rst_irq", irq, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit");
    end
endmodule

`default_nettype wire
